// File: rtl/sumador_serial.sv
// Bit-serial N-bit adder: one full adder, LSB first, result published on entry to DONE.
// Optional signed-overflow output ovf is enabled by defining SUMADOR_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start; sum/co hold the last result
// SHIFT | one bit position per cycle, N cycles total
// DONE  | result valid, done pulses for one cycle
module sumador_serial #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
`ifdef SUMADOR_SERIAL_OVF_EN
    output logic         ovf,
`endif
    output logic [N-1:0] sum,
    output logic         co
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  res;
    logic [N-1:0]  res_n;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          fa_s;
    logic          fa_co;
    logic          last_bit;

    assign fa_s     = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_co    = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last_bit = (cnt == CW'(N - 1));
    assign res_n    = {fa_s, {(N-1){1'b0}}} | (res >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (last_bit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            co    <= 1'b0;
`ifdef SUMADOR_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= ci;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    res   <= res_n;
                    cnt   <= cnt + CW'(1);
                    // Outputs move only on the final bit so partial sums stay hidden.
                    if (last_bit) begin
                        sum <= res_n;
                        co  <= fa_co;
`ifdef SUMADOR_SERIAL_OVF_EN
                        ovf <= carry ^ fa_co;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_serial.sv
// Scoreboard bench for sumador_serial: driver pushes reference results, a negedge monitor checks each done pulse.
// Also checks ovf when SUMADOR_SERIAL_OVF_EN is defined.
module tb_sumador_serial;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] sum;
        logic         co;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         ci_i;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         co;
`ifdef SUMADOR_SERIAL_OVF_EN
    logic         ovf;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t exp_q[$];
    exp_t prev;

    sumador_serial #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .ci    (ci_i),
        .busy  (busy),
        .done  (done),
`ifdef SUMADOR_SERIAL_OVF_EN
        .ovf   (ovf),
`endif
        .sum   (sum),
        .co    (co)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input int a, input int b, input int c, input int dcyc);
        exp_t m;
        int tot = a + b + c;
        int sa  = (a >= (1 << (N-1))) ? a - (1 << N) : a;
        int sb  = (b >= (1 << (N-1))) ? b - (1 << N) : b;
        int st  = sa + sb + c;
        m.sum = tot[N-1:0];
        m.co  = (tot >= (1 << N));
        m.ovf = (st > (1 << (N-1)) - 1) || (st < -(1 << (N-1)));
        m.cyc = dcyc;
        return m;
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("co", 32'(co), 32'(e.co));
                check("done_cycle", cyc, e.cyc);
                check("busy_in_done", 32'(busy), 1);
`ifdef SUMADOR_SERIAL_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // One addition. hold=1 keeps start high and churns operands every cycle.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input bit hold);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a_i   = a;
        b_i   = b;
        ci_i  = c;
        e = model(int'(a), int'(b), int'(c), cyc + 1 + N);
        exp_q.push_back(e);
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            start = hold ? 1'b1 : 1'($urandom);
            a_i   = N'($urandom);
            b_i   = N'($urandom);
            ci_i  = 1'($urandom);
            if (k == N - 1) begin
                check("sum_hold_during_shift", 32'(sum), 32'(prev.sum));
                check("co_hold_during_shift", 32'(co), 32'(prev.co));
            end
        end
        prev = e;
    endtask

    // Reset on the second SHIFT cycle, optionally together with start.
    task automatic reset_mid_op(input bit with_start);
        @(negedge clk);
        start = 1'b1;
        a_i   = N'($urandom);
        b_i   = N'($urandom);
        ci_i  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        start = with_start;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_co", 32'(co), 0);
`ifdef SUMADOR_SERIAL_OVF_EN
        check("rst_ovf", 32'(ovf), 0);
`endif
        prev.sum = '0;
        prev.co  = 1'b0;
        repeat (N + 3) @(negedge clk);
        check("rst_no_busy_after", 32'(busy), 0);
    endtask

    initial begin
        logic [N-1:0] da [7] = '{4'd7, 4'd15, 4'd9, 4'd7, 4'd8, 4'd0, 4'd15};
        logic [N-1:0] db [7] = '{4'd8, 4'd1,  4'd9, 4'd1, 4'd8, 4'd0, 4'd15};
        logic         dc [7] = '{1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        rst   = 1'b1;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        ci_i  = 1'b0;
        prev  = model(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_co", 32'(co), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) issue(da[i], db[i], dc[i], 1'b0);

        reset_mid_op(1'b0);
        issue(4'd9, 4'd9, 1'b1, 1'b0);
        reset_mid_op(1'b1);
        issue(4'd7, 4'd1, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) issue(N'($urandom), N'($urandom), 1'($urandom), 1'b1);
        @(negedge clk);
        start = 1'b0;
        // Drop the expectation for a start the held-high stream may have launched.
        repeat (N + 4) @(negedge clk);
        exp_q.delete();
        prev.sum = sum;
        prev.co  = co;

        for (int i = 0; i < 300; i++) issue(N'($urandom), N'($urandom), 1'($urandom), 1'b0);

        @(negedge clk);
        start = 1'b0;
        repeat (N + 4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
